// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared opcodes, FSM state type and lane constants for mem_access_unit
package mem_pkg;

   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;

   typedef enum logic {ST_IDLE, ST_BUSY} mem_state_t;

   typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t;

   // Big-endian lanes: byte address 0 lives in bits 31:24.
   localparam logic [3:0] SEL_BYTE0   = 4'b1000;
   localparam logic [3:0] SEL_HALF_HI = 4'b1100;
   localparam logic [3:0] SEL_HALF_LO = 4'b0011;
   localparam logic [3:0] SEL_WORD    = 4'b1111;

   function automatic mem_size_t op_size(input logic [7:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
         OP_LW, OP_SW:         op_size = SZ_WORD;
         default:              op_size = SZ_NONE;
      endcase
   endfunction

   function automatic logic op_is_store(input logic [7:0] op);
      op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic op_is_signed(input logic [7:0] op);
      op_is_signed = (op == OP_LB) || (op == OP_LH);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-enable generation, store replication and load extension
module mem_lane_align (
   input  logic [7:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_in,
   input  logic [31:0] load_in,
   output logic [3:0]  sel,
   output logic [31:0] store_out,
   output logic [31:0] load_out
);
   import mem_pkg::*;

   mem_size_t   size;
   logic        sign_ext;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign size     = op_size(op);
   assign sign_ext = op_is_signed(op);

   // byte enables and store-data replication across all lanes
   always_comb begin
      sel       = 4'b0000;
      store_out = store_in;
      case (size)
         SZ_BYTE: begin
            sel       = SEL_BYTE0 >> addr_lo;
            store_out = {4{store_in[7:0]}};
         end
         SZ_HALF: begin
            sel       = addr_lo[1] ? SEL_HALF_LO : SEL_HALF_HI;
            store_out = {2{store_in[15:0]}};
         end
         SZ_WORD: sel = SEL_WORD;
         default: ;
      endcase
   end

   // pick the addressed lane of the read data and extend it to 32 bits
   always_comb begin
      byte_v = load_in[31:24];
      case (addr_lo)
         2'd1:    byte_v = load_in[23:16];
         2'd2:    byte_v = load_in[15:8];
         2'd3:    byte_v = load_in[7:0];
         default: byte_v = load_in[31:24];
      endcase
      half_v = addr_lo[1] ? load_in[15:0] : load_in[31:16];
      case (size)
         SZ_BYTE: load_out = {{24{sign_ext & byte_v[7]}}, byte_v};
         SZ_HALF: load_out = {{16{sign_ext & half_v[15]}}, half_v};
         default: load_out = load_in;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - pipeline memory stage with bus handshake and timeout; optional MEM_ALIGN_EXC_EN
module mem_access_unit #(
   parameter int ADDR_W      = 32,
   parameter int REG_AW      = 5,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [REG_AW-1:0] wd_in,
   input  logic              wreg_in,
   input  logic [31:0]       wdata_in,
   input  logic [7:0]        aluop_in,
   input  logic [ADDR_W-1:0] mem_addr_in,
   input  logic [31:0]       reg2_in,
   output logic              mem_ce_out,
   output logic              mem_we_out,
   output logic [3:0]        mem_sel_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [31:0]       mem_data_out,
   input  logic [31:0]       mem_data_in,
   input  logic              mem_ack_in,
   output logic              valid_out,
   output logic [REG_AW-1:0] wd_out,
   output logic              wreg_out,
   output logic [31:0]       wdata_out,
   output logic              stall_req_out,
   output logic              bus_err_out,
   output logic              exc_adel_out,
   output logic              exc_ades_out,
   output logic [ADDR_W-1:0] badvaddr_out
);
   import mem_pkg::*;

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

   mem_state_t        state, state_nx;
   mem_size_t         size;
   logic              is_store, is_load, misaligned;
   logic [ADDR_W-1:0] addr_eff;
   logic [7:0]        op_q;
   logic [1:0]        addr_lo_q;
   logic [REG_AW-1:0] wd_q;
   logic              wreg_q;
   logic [CNT_W-1:0]  cnt;
   logic              go_pass, go_busy, go_exc, fin_ack, fin_tmo;
   logic [7:0]        lane_op;
   logic [1:0]        lane_addr;
   logic [3:0]        lane_sel;
   logic [31:0]       lane_store, lane_load;

   assign size     = op_size(aluop_in);
   assign is_store = op_is_store(aluop_in);
   assign is_load  = (size != SZ_NONE) && !is_store;

`ifdef MEM_ALIGN_EXC_EN
   assign addr_eff   = mem_addr_in;
   assign misaligned = ((size == SZ_HALF) && mem_addr_in[0]) ||
                       ((size == SZ_WORD) && (mem_addr_in[1:0] != 2'b00));
`else
   // misaligned accesses are silently rounded down to their natural boundary
   always_comb begin
      addr_eff = mem_addr_in;
      if (size == SZ_HALF)      addr_eff[0]   = 1'b0;
      else if (size == SZ_WORD) addr_eff[1:0] = 2'b00;
   end
   assign misaligned   = 1'b0;
   assign exc_adel_out = 1'b0;
   assign exc_ades_out = 1'b0;
   assign badvaddr_out = '0;
`endif

   // While busy the lane logic works from the op captured at accept time.
   assign lane_op   = (state == ST_BUSY) ? op_q : aluop_in;
   assign lane_addr = (state == ST_BUSY) ? addr_lo_q : addr_eff[1:0];

   mem_lane_align u_lane (
      .op        (lane_op),
      .addr_lo   (lane_addr),
      .store_in  (reg2_in),
      .load_in   (mem_data_in),
      .sel       (lane_sel),
      .store_out (lane_store),
      .load_out  (lane_load)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // next state, stall request and one-hot event strobes for the datapath
   always_comb begin
      state_nx      = state;
      stall_req_out = 1'b0;
      go_pass       = 1'b0;
      go_busy       = 1'b0;
      go_exc        = 1'b0;
      fin_ack       = 1'b0;
      fin_tmo       = 1'b0;
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               if (valid_in) begin
                  if (size == SZ_NONE) go_pass = 1'b1;
                  else if (misaligned) go_exc = 1'b1;
                  else begin
                     go_busy       = 1'b1;
                     stall_req_out = 1'b1;
                     state_nx      = ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               stall_req_out = 1'b1;
               if (mem_ack_in) begin
                  fin_ack  = 1'b1;
                  state_nx = ST_IDLE;
               end else if ((TIMEOUT_CYC > 0) && (cnt == CNT_LAST)) begin
                  fin_tmo  = 1'b1;
                  state_nx = ST_IDLE;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // registered bus, writeback and status outputs plus the busy-cycle counter
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_ce_out   <= 1'b0;
         mem_we_out   <= 1'b0;
         mem_sel_out  <= 4'b0000;
         mem_addr_out <= '0;
         mem_data_out <= '0;
         valid_out    <= 1'b0;
         wd_out       <= '0;
         wreg_out     <= 1'b0;
         wdata_out    <= '0;
         bus_err_out  <= 1'b0;
         op_q         <= '0;
         addr_lo_q    <= '0;
         wd_q         <= '0;
         wreg_q       <= 1'b0;
         cnt          <= '0;
`ifdef MEM_ALIGN_EXC_EN
         exc_adel_out <= 1'b0;
         exc_ades_out <= 1'b0;
         badvaddr_out <= '0;
`endif
      end else begin
         valid_out   <= 1'b0;
         bus_err_out <= 1'b0;
`ifdef MEM_ALIGN_EXC_EN
         exc_adel_out <= 1'b0;
         exc_ades_out <= 1'b0;
`endif
         if (go_pass) begin
            valid_out <= 1'b1;
            wd_out    <= wd_in;
            wreg_out  <= wreg_in;
            wdata_out <= wdata_in;
         end
         if (go_exc) begin
            valid_out <= 1'b1;
            wd_out    <= wd_in;
            wreg_out  <= 1'b0;
            wdata_out <= '0;
`ifdef MEM_ALIGN_EXC_EN
            exc_adel_out <= is_load;
            exc_ades_out <= is_store;
            badvaddr_out <= mem_addr_in;
`endif
         end
         if (go_busy) begin
            mem_ce_out   <= 1'b1;
            mem_we_out   <= is_store;
            mem_sel_out  <= lane_sel;
            mem_addr_out <= addr_eff;
            mem_data_out <= is_store ? lane_store : 32'h0;
            op_q         <= aluop_in;
            addr_lo_q    <= addr_eff[1:0];
            wd_q         <= wd_in;
            wreg_q       <= wreg_in & is_load;
            cnt          <= '0;
         end else if (state == ST_BUSY) begin
            cnt <= cnt + 1'b1;
         end
         if (fin_ack || fin_tmo) begin
            mem_ce_out   <= 1'b0;
            mem_we_out   <= 1'b0;
            mem_sel_out  <= 4'b0000;
            mem_addr_out <= '0;
            mem_data_out <= '0;
            valid_out    <= 1'b1;
            wd_out       <= wd_q;
         end
         if (fin_ack) begin
            wreg_out  <= wreg_q;
            wdata_out <= op_is_store(op_q) ? 32'h0 : lane_load;
         end
         if (fin_tmo) begin
            wreg_out    <= 1'b0;
            wdata_out   <= '0;
            bus_err_out <= 1'b1;
         end
      end
   end

endmodule
